// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf
// Buffered 1-to-2 demultiplexer. One input stream (data_i/select_i/valid_i,
// ready_o) is steered by select_i into one of two single-entry output lanes,
// each with its own valid/ready handshake and a wrapping delivery counter.
//
// Ports
//   clk_i              clock, rising edge
//   rst_i              synchronous reset, active-high
//   data_i, select_i   input word and destination lane (0 or 1)
//   valid_i, ready_o   input handshake; ready_o is combinational
//   data0_o, valid0_o  lane 0 output word and valid
//   ready0_i           lane 0 consumer ready
//   data1_o, valid1_o  lane 1 output word and valid
//   ready1_i           lane 1 consumer ready
//   count0_o, count1_o words delivered per lane, modulo 2^CNT_W
//
// Lane states (identical for both lanes)
//   state | meaning
//   EMPTY | no word held, validk_o = 0
//   FULL  | word held in datak_o, validk_o = 1, waiting for readyk_i
module demux_1to2_buf #(
  parameter int size  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [size-1:0]  data_i,
  input  logic             select_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [size-1:0]  data0_o,
  output logic             valid0_o,
  input  logic             ready0_i,
  output logic [size-1:0]  data1_o,
  output logic             valid1_o,
  input  logic             ready1_i,
  output logic [CNT_W-1:0] count0_o,
  output logic [CNT_W-1:0] count1_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

  lane_state_t state0;
  lane_state_t state1;

  logic lane0_free;
  logic lane1_free;
  logic xfer;
  logic fill0;
  logic fill1;
  logic deliver0;
  logic deliver1;

  assign valid0_o = (state0 == FULL);
  assign valid1_o = (state1 == FULL);

  // A lane can take a word if it is empty or is being drained this cycle,
  // which gives one-word-per-cycle pass-through into a lane with ready high.
  assign lane0_free = ~valid0_o | ready0_i;
  assign lane1_free = ~valid1_o | ready1_i;

  // Only the selected lane gates the input. During reset the lanes are being
  // cleared, so the input side reports ready; the accepted word is discarded
  // because reset dominates every state update below.
  assign ready_o = rst_i | (select_i ? lane1_free : lane0_free);

  assign xfer     = valid_i & ready_o & ~rst_i;
  assign fill0    = xfer & ~select_i;
  assign fill1    = xfer &  select_i;
  assign deliver0 = valid0_o & ready0_i;
  assign deliver1 = valid1_o & ready1_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state0   <= EMPTY;
      state1   <= EMPTY;
      data0_o  <= '0;
      data1_o  <= '0;
      count0_o <= '0;
      count1_o <= '0;
    end else begin
      // Lane 0: a fill wins over a delivery so a same-cycle refill stays FULL.
      if (fill0) begin
        state0  <= FULL;
        data0_o <= data_i;
      end else if (deliver0) begin
        state0 <= EMPTY;
      end
      if (deliver0) begin
        count0_o <= count0_o + CNT_W'(1);
      end

      if (fill1) begin
        state1  <= FULL;
        data1_o <= data_i;
      end else if (deliver1) begin
        state1 <= EMPTY;
      end
      if (deliver1) begin
        count1_o <= count1_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_1to2_buf.sv
module tb_demux_1to2_buf;

  localparam int W  = 32;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [W-1:0]  data_i;
  logic          select_i;
  logic          valid_i;
  logic          ready_o;
  logic [W-1:0]  data0_o;
  logic          valid0_o;
  logic          ready0_i;
  logic [W-1:0]  data1_o;
  logic          valid1_o;
  logic          ready1_i;
  logic [CW-1:0] count0_o;
  logic [CW-1:0] count1_o;

  demux_1to2_buf #(.size(W), .CNT_W(CW)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .count0_o (count0_o),
    .count1_o (count1_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0]  q0[$];
  logic [W-1:0]  q1[$];
  logic [CW-1:0] m_c0 = '0;
  logic [CW-1:0] m_c1 = '0;
  bit            mon_en = 1'b0;

  // Inputs change just after posedge, so the negedge sees the values the
  // next posedge will act on.
  always @(negedge clk_i) begin
    if (mon_en) begin
      logic exp_rdy;
      if (rst_i) exp_rdy = 1'b1;
      else if (select_i) exp_rdy = (q1.size() == 0) || ready1_i;
      else exp_rdy = (q0.size() == 0) || ready0_i;

      chk("mon_ready", {63'd0, ready_o}, {63'd0, exp_rdy});
      chk("mon_valid0", {63'd0, valid0_o}, {63'd0, q0.size() != 0});
      chk("mon_valid1", {63'd0, valid1_o}, {63'd0, q1.size() != 0});
      chk("mon_count0", {56'd0, count0_o}, {56'd0, m_c0});
      chk("mon_count1", {56'd0, count1_o}, {56'd0, m_c1});
      if (q0.size() != 0) chk("mon_data0", {32'd0, data0_o}, {32'd0, q0[0]});
      if (q1.size() != 0) chk("mon_data1", {32'd0, data1_o}, {32'd0, q1[0]});

      if (rst_i) begin
        q0.delete();
        q1.delete();
        m_c0 = '0;
        m_c1 = '0;
      end else begin
        if (q0.size() != 0 && ready0_i) begin
          void'(q0.pop_front());
          m_c0 = m_c0 + 8'd1;
        end
        if (q1.size() != 0 && ready1_i) begin
          void'(q1.pop_front());
          m_c1 = m_c1 + 8'd1;
        end
        if (valid_i && exp_rdy) begin
          if (select_i) q1.push_back(data_i);
          else q0.push_back(data_i);
        end
      end
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          v;
    logic          s;
    logic [W-1:0]  d;
    logic          r0;
    logic          r1;
    logic          rdy;
    logic          v0;
    logic [W-1:0]  d0;
    logic          v1;
    logic [W-1:0]  d1;
    logic [CW-1:0] c0;
    logic [CW-1:0] c1;
  } vec_t;

  vec_t tbl[15];

  task automatic drive(input logic v, input logic s, input logic [W-1:0] d,
                       input logic r0, input logic r1);
    valid_i  = v;
    select_i = s;
    data_i   = d;
    ready0_i = r0;
    ready1_i = r1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           v  s  d              r0 r1 rdy v0 d0             v1 d1     c0 c1
    tbl[0]  = '{1, 0, 32'hA5A5A5A5, 0, 0, 1, 1, 32'hA5A5A5A5, 0, 32'h0, 0, 0};
    tbl[1]  = '{0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        0, 32'h0, 1, 0};
    tbl[2]  = '{1, 1, 32'h11,       0, 0, 1, 0, 32'h0,        1, 32'h11, 1, 0};
    tbl[3]  = '{1, 1, 32'h22,       0, 0, 0, 0, 32'h0,        1, 32'h11, 1, 0};
    tbl[4]  = '{1, 1, 32'h22,       0, 1, 1, 0, 32'h0,        1, 32'h22, 1, 1};
    tbl[5]  = '{0, 1, 32'h0,        0, 1, 1, 0, 32'h0,        0, 32'h0, 1, 2};
    tbl[6]  = '{1, 0, 32'h44,       0, 0, 1, 1, 32'h44,       0, 32'h0, 1, 2};
    tbl[7]  = '{1, 0, 32'h55,       0, 0, 0, 1, 32'h44,       0, 32'h0, 1, 2};
    tbl[8]  = '{1, 1, 32'h33,       0, 0, 1, 1, 32'h44,       1, 32'h33, 1, 2};
    tbl[9]  = '{0, 1, 32'h0,        0, 1, 1, 1, 32'h44,       0, 32'h0, 1, 3};
    tbl[10] = '{1, 0, 32'h66,       1, 0, 1, 1, 32'h66,       0, 32'h0, 2, 3};
    tbl[11] = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0, 3, 3};
    tbl[12] = '{1, 1, 32'h77,       0, 0, 1, 0, 32'h0,        1, 32'h77, 3, 3};
    tbl[13] = '{1, 0, 32'h88,       0, 0, 1, 1, 32'h88,       1, 32'h77, 3, 3};
    tbl[14] = '{0, 0, 32'h0,        1, 1, 1, 0, 32'h0,        0, 32'h0, 4, 4};

    rst_i = 1'b1;
    drive(0, 0, '0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    mon_en = 1'b1;

    chk("rst_valid0", {63'd0, valid0_o}, 64'd0);
    chk("rst_valid1", {63'd0, valid1_o}, 64'd0);
    chk("rst_data0", {32'd0, data0_o}, 64'd0);
    chk("rst_data1", {32'd0, data1_o}, 64'd0);
    chk("rst_count0", {56'd0, count0_o}, 64'd0);
    chk("rst_count1", {56'd0, count1_o}, 64'd0);
    chk("rst_ready", {63'd0, ready_o}, 64'd1);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
      @(negedge clk_i);
      chk($sformatf("vec%0d_ready", i), {63'd0, ready_o}, {63'd0, tbl[i].rdy});
      tick();
      chk($sformatf("vec%0d_valid0", i), {63'd0, valid0_o}, {63'd0, tbl[i].v0});
      chk($sformatf("vec%0d_valid1", i), {63'd0, valid1_o}, {63'd0, tbl[i].v1});
      chk($sformatf("vec%0d_count0", i), {56'd0, count0_o}, {56'd0, tbl[i].c0});
      chk($sformatf("vec%0d_count1", i), {56'd0, count1_o}, {56'd0, tbl[i].c1});
      if (tbl[i].v0) chk($sformatf("vec%0d_data0", i), {32'd0, data0_o}, {32'd0, tbl[i].d0});
      if (tbl[i].v1) chk($sformatf("vec%0d_data1", i), {32'd0, data1_o}, {32'd0, tbl[i].d1});
    end

    // Both lanes full, then a one-cycle reset with a lane-0 word presented.
    drive(1, 1, 32'hAB, 0, 0);
    tick();
    drive(1, 0, 32'hCD, 0, 0);
    tick();
    chk("pre_rst_valid0", {63'd0, valid0_o}, 64'd1);
    chk("pre_rst_valid1", {63'd0, valid1_o}, 64'd1);
    rst_i = 1'b1;
    drive(1, 0, 32'hEE, 0, 0);
    @(negedge clk_i);
    chk("in_rst_ready", {63'd0, ready_o}, 64'd1);
    tick();
    rst_i = 1'b0;
    drive(0, 0, '0, 0, 0);
    chk("post_rst_valid0", {63'd0, valid0_o}, 64'd0);
    chk("post_rst_valid1", {63'd0, valid1_o}, 64'd0);
    chk("post_rst_count0", {56'd0, count0_o}, 64'd0);
    chk("post_rst_count1", {56'd0, count1_o}, 64'd0);
    chk("post_rst_data0", {32'd0, data0_o}, 64'd0);
    chk("post_rst_ready", {63'd0, ready_o}, 64'd1);
    tick();
    chk("post_rst_no_ghost", {63'd0, valid0_o}, 64'd0);

    // Stream 256 lane-0 words back to back; counter wraps 255 -> 0.
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 32'h1000 + i, 1, 0);
      @(negedge clk_i);
      if (ready_o !== 1'b1) chk($sformatf("stream%0d_ready", i), {63'd0, ready_o}, 64'd1);
      tick();
    end
    chk("stream_count0_255", {56'd0, count0_o}, 64'd255);
    chk("stream_data0_last", {32'd0, data0_o}, 64'h10FF);
    drive(0, 0, '0, 1, 0);
    tick();
    chk("stream_count0_wrap", {56'd0, count0_o}, 64'd0);
    chk("stream_count1", {56'd0, count1_o}, 64'd0);
    chk("stream_valid0", {63'd0, valid0_o}, 64'd0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    drive(0, 0, '0, 1, 1);
    repeat (3) tick();
    chk("final_q0_empty", 64'(q0.size()), 64'd0);
    chk("final_q1_empty", 64'(q1.size()), 64'd0);
    chk("final_count0", {56'd0, count0_o}, {56'd0, m_c0});
    chk("final_count1", {56'd0, count1_o}, {56'd0, m_c1});
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
